// File: rtl/f_s.sv
// Registered ripple full subtractor: {f_Bo, f_Df} = f_A - f_B - f_Bi, one cycle after f_en.
// Optional status outputs (f_zero, f_bcnt) are built when F_S_STATUS_EN is defined.
module f_s #(
  parameter int WIDTH = 1
) (
  input  logic             f_clk,
  input  logic             f_rst_n,
  input  logic             f_en,
  input  logic [WIDTH-1:0] f_A,
  input  logic [WIDTH-1:0] f_B,
  input  logic             f_Bi,
  output logic [WIDTH-1:0] f_Df,
  output logic             f_Bo,
`ifdef F_S_STATUS_EN
  output logic             f_zero,
  output logic [15:0]      f_bcnt,
`endif
  output logic             f_vld
);

`ifdef F_S_STATUS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  logic [WIDTH-1:0] diff_p0;
  logic [WIDTH:0]   brw_p0;
  logic [WIDTH-1:0] df_p1;
  logic             bo_p1;
  logic             vld_p1;

  // Stage p0: combinational borrow chain of single-bit cells
  assign brw_p0[0] = f_Bi;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign diff_p0[i]  = f_A[i] ^ f_B[i] ^ brw_p0[i];
    assign brw_p0[i+1] = (~f_A[i] & f_B[i]) | (~f_A[i] & brw_p0[i]) | (f_B[i] & brw_p0[i]);
  end

  // Stage p1: result registers
  always_ff @(posedge f_clk or negedge f_rst_n) begin
    if (!f_rst_n) begin
      df_p1  <= '0;
      bo_p1  <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= f_en;
      if (f_en) begin
        df_p1 <= diff_p0;
        bo_p1 <= brw_p0[WIDTH];
      end
    end
  end

`ifdef F_S_STATUS_EN
  logic        zero_p1;
  logic [15:0] bcnt_p1;

  always_ff @(posedge f_clk or negedge f_rst_n) begin
    if (!f_rst_n) begin
      zero_p1 <= 1'b0;
      bcnt_p1 <= '0;
    end else if (f_en) begin
      zero_p1 <= (diff_p0 == '0);
      if (brw_p0[WIDTH]) bcnt_p1 <= sat_inc(bcnt_p1);
    end
  end

  assign f_zero = zero_p1;
  assign f_bcnt = bcnt_p1;
`endif

  assign f_Df  = df_p1;
  assign f_Bo  = bo_p1;
  assign f_vld = vld_p1;

endmodule

// File: tb/tb_f_s.sv
// Scoreboard bench for f_s: a WIDTH=1 and a WIDTH=4 instance, status outputs checked when F_S_STATUS_EN is defined.
module tb_f_s;

  logic       clk;
  logic       rst_n;
  logic       en1, en4;
  logic [0:0] a1, b1;
  logic [3:0] a4, b4;
  logic       bi1, bi4;
  logic [0:0] df1;
  logic [3:0] df4;
  logic       bo1, bo4, vld1, vld4;
`ifdef F_S_STATUS_EN
  logic        zero1, zero4;
  logic [15:0] bcnt1, bcnt4;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [4:0] q1[$];
  logic [4:0] q4[$];

  f_s #(.WIDTH(1)) u_dut1 (
    .f_clk(clk), .f_rst_n(rst_n), .f_en(en1), .f_A(a1), .f_B(b1), .f_Bi(bi1),
    .f_Df(df1), .f_Bo(bo1),
`ifdef F_S_STATUS_EN
    .f_zero(zero1), .f_bcnt(bcnt1),
`endif
    .f_vld(vld1)
  );

  f_s #(.WIDTH(4)) u_dut4 (
    .f_clk(clk), .f_rst_n(rst_n), .f_en(en4), .f_A(a4), .f_B(b4), .f_Bi(bi4),
    .f_Df(df4), .f_Bo(bo4),
`ifdef F_S_STATUS_EN
    .f_zero(zero4), .f_bcnt(bcnt4),
`endif
    .f_vld(vld4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Reference: {borrow, diff} from integer arithmetic, modulo 2^w
  function automatic logic [4:0] ref_sub(input int w, input int a, input int b, input int bi);
    int r;
    int m;
    logic [4:0] res;
    m = 1 << w;
    r = a - b - bi;
    res = '0;
    res[3:0] = 4'((r + 2 * m) % m);
    res[4] = (r < 0);
    return res;
  endfunction

  task automatic idle();
    en1 = 1'b0;
    en4 = 1'b0;
  endtask

  // Advance one edge and score whatever the DUTs produced.
  task automatic tick();
    logic [4:0] e;
    @(posedge clk);
    #1;
    if (vld1 === 1'b1) begin
      if (q1.size() == 0) chk("w1_unexpected_vld", 1, 0);
      else begin
        e = q1.pop_front();
        chk("w1_df", 64'(df1), 64'(e[0]));
        chk("w1_bo", 64'(bo1), 64'(e[4]));
      end
    end
    if (vld4 === 1'b1) begin
      if (q4.size() == 0) chk("w4_unexpected_vld", 1, 0);
      else begin
        e = q4.pop_front();
        chk("w4_df", 64'(df4), 64'(e[3:0]));
        chk("w4_bo", 64'(bo4), 64'(e[4]));
      end
    end
  endtask

  task automatic drv1(input int a, input int b, input int bi);
    en1 = 1'b1; a1 = 1'(a); b1 = 1'(b); bi1 = 1'(bi);
    q1.push_back(ref_sub(1, a, b, bi));
  endtask

  task automatic drv4(input int a, input int b, input int bi);
    en4 = 1'b1; a4 = 4'(a); b4 = 4'(b); bi4 = 1'(bi);
    q4.push_back(ref_sub(4, a, b, bi));
  endtask

  task automatic do_reset();
    idle();
    #2 rst_n = 1'b0;
    #1;
    q1.delete();
    q4.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    a1 = '0; b1 = '0; bi1 = 1'b0;
    a4 = '0; b4 = '0; bi4 = 1'b0;
    #12;
    chk("rst_df4", 64'(df4), 0);
    chk("rst_bo4", 64'(bo4), 0);
    chk("rst_vld1", 64'(vld1), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // WIDTH=1 truth-table sweep, back to back
    for (int v = 0; v < 8; v++) begin
      drv1((v >> 2) & 1, (v >> 1) & 1, v & 1);
      tick();
      if (v > 0) chk("w1_sweep_vld", 64'(vld1), 1);
    end
    idle();
    tick();
    chk("w1_sweep_drain", 64'(vld1), 0);

    // Hold: capture 1-0-0, then drop f_en while inputs move to 0,1,1 and X
    drv1(1, 0, 0);
    tick();
    idle();
    a1 = 1'b0; b1 = 1'b1; bi1 = 1'b1;
    tick();
    chk("hold_df", 64'(df1), 1);
    chk("hold_bo", 64'(bo1), 0);
    chk("hold_vld", 64'(vld1), 0);
    a1 = 'x; b1 = 'x; bi1 = 1'bx;
    tick();
    chk("hold_x_df", 64'(df1), 1);
    chk("hold_x_bo", 64'(bo1), 0);

    // Async reset between edges clears a visible result immediately
    drv1(1, 1, 1);
    tick();
    chk("pre_rst_vld", 64'(vld1), 1);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("async_df", 64'(df1), 0);
    chk("async_bo", 64'(bo1), 0);
    chk("async_vld", 64'(vld1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drv1(1, 1, 1);
    tick();
    chk("post_rst_vld", 64'(vld1), 1);
    idle();
    tick();

    // WIDTH=4 directed boundaries and wrap-around
    drv4(0, 1, 0);   tick();
    chk("w4_wrap_df", 64'(df4), 64'hF);
    drv4(9, 3, 1);   tick();
    chk("w4_9_3_1_df", 64'(df4), 64'h5);
    drv4(7, 7, 1);   tick();
    chk("w4_eq_bi_df", 64'(df4), 64'hF);
    chk("w4_eq_bi_bo", 64'(bo4), 1);
    drv4(15, 0, 0);  tick();
    chk("w4_max_df", 64'(df4), 64'hF);
    chk("w4_max_bo", 64'(bo4), 0);
    for (int k = 0; k < 24; k++) begin
      drv4($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
      tick();
    end
    idle();
    tick();

`ifdef F_S_STATUS_EN
    do_reset();
    chk("st_rst_bcnt", 64'(bcnt4), 0);
    chk("st_rst_zero", 64'(zero4), 0);
    drv4(5, 5, 0); tick();
    chk("st_zero0", 64'(zero4), 1);
    drv4(0, 1, 0); tick();
    chk("st_zero1", 64'(zero4), 0);
    drv4(2, 1, 0); tick();
    chk("st_zero2", 64'(zero4), 0);
    chk("st_bcnt3", 64'(bcnt4), 1);
    idle();
    tick();
    chk("st_hold_bcnt", 64'(bcnt4), 1);
    for (int k = 0; k < 65540; k++) begin
      drv4(0, 1, 0);
      tick();
    end
    idle();
    tick();
    chk("st_bcnt_sat", 64'(bcnt4), 64'hFFFF);
`endif

    chk("q1_drain", 64'(q1.size()), 0);
    chk("q4_drain", 64'(q4.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout act=%0d exp=0", 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/f_s.md
Name: f_s

Overview:
- Registered full subtractor: computes A − B − Bi and registers the difference and borrow-out.
- WIDTH=1 is the classic single-bit full-subtractor cell. Wider settings chain single-bit cells in ripple fashion.
- Used as the arithmetic leaf in datapaths that need a clocked borrow chain. Results appear one cycle after the operands are qualified by f_en.

Parameters:
- WIDTH, 1, operand/difference width in bits (legal 1..64).

Ports:
- f_clk  input  1  clock; rising-edge active.
- f_rst_n  input  1  asynchronous active-low reset.
- f_en  input  1  operand qualifier; capture on this cycle's edge when high.
- f_A  input  WIDTH  minuend, unsigned.
- f_B  input  WIDTH  subtrahend, unsigned.
- f_Bi  input  1  borrow-in.
- f_Df  output  WIDTH  registered difference.
- f_Bo  output  1  registered borrow-out.
- f_vld  output  1  high for one cycle per captured operation.

Behaviour:
- Per-bit cell i:
  - d[i] = a[i] ^ b[i] ^ bin[i]
  - bout[i] = (~a[i] & b[i]) | (~a[i] & bin[i]) | (b[i] & bin[i])
  - bin[0] = f_Bi; bin[i+1] = bout[i]; final borrow = bout[WIDTH-1].
- The chain is combinational. Net result: {borrow, diff} = A − B − Bi computed over WIDTH+1 bits. borrow=1 exactly when A < B + Bi as unsigned values.
- Latency 1 cycle. On a rising f_clk edge with f_en=1:
  - f_Df <= diff
  - f_Bo <= borrow
  - f_vld <= 1
- On an edge with f_en=0: f_Df and f_Bo hold their previous values; f_vld <= 0.
- Back-to-back f_en=1 is allowed: full throughput, one result per cycle, no stall or backpressure.
- Reset (f_rst_n=0, asynchronous, takes effect immediately regardless of f_clk):
  - f_Df = 0, f_Bo = 0, f_vld = 0.
  - Reset asserted mid-operation discards the in-flight result.
  - The first capture after reset release happens on the first rising edge where f_rst_n=1 and f_en=1.
- Wrap-around: the difference is always modulo 2^WIDTH. Example, WIDTH=4: 0 − 1 − 0 gives Df=4'hF, Bo=1.
- Boundary cases:
  - A = B with Bi=1 → Df = all-ones, Bo=1.
  - A = max, B=0, Bi=0 → Df = max, Bo=0.
- X/Z on inputs while f_en=0 must not disturb the held outputs.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: F_S_STATUS_EN.
- Defined — adds two outputs:
  - f_zero (1 bit, registered): set to (diff == 0) on each captured operation; holds otherwise; reset 0.
  - f_bcnt (16 bits): counts captured operations with borrow=1; saturates at 16'hFFFF; reset 0.
- Not defined: neither port exists, no extra logic; core behaviour is identical.

Test Plan:
- WIDTH=1, f_en=1, sweep {A,B,Bi} through 000..111 every cycle → after 1 cycle, in order:
  - (Df,Bo) = (0,0), (1,1), (1,1), (0,1), (1,0), (0,0), (0,0), (1,1)
  - f_vld=1 each cycle.
- Hold: capture A=1, B=0, Bi=0 (Df=1, Bo=0), then f_en=0 while inputs change to 0,1,1 → Df=1, Bo=0 held; f_vld=0.
- Async reset: outputs Df=1, Bo=1, f_vld=1; assert f_rst_n=0 between clock edges → all outputs 0 immediately. Release, then apply f_en=1 with 1,1,1 → Df=1, Bo=1 one cycle later.
- WIDTH=4:
  - A=0, B=1, Bi=0 → Df=4'hF, Bo=1.
  - A=4'h9, B=4'h3, Bi=1 → Df=4'h5, Bo=0.
  - A=4'h7, B=4'h7, Bi=1 → Df=4'hF, Bo=1.
- F_S_STATUS_EN with WIDTH=4: three captures (5−5−0, 0−1−0, 2−1−0) →
  - f_zero sequence 1, 0, 0
  - f_bcnt = 1
  - forcing 65540 borrow captures → f_bcnt saturates at 16'hFFFF.
